edge_frame_buffer: RTL and testbench

// Ping-pong 1-bit frame store downstream of the Sobel edge detector. Captures the

---
 rtl/edge_frame_buffer.sv | 170 +++++++++++++++++
 tb/tb_edge_frame_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_buffer.sv
// Ping-pong 1-bit frame store between the Sobel edge stage and the LCD driver.
// The edge stream fills the back bank; the front bank is mapped to RGB565 inside a screen window.
module edge_frame_buffer #(
    parameter int          IMG_W    = 158,
    parameter int          IMG_H    = 158,
    parameter int          X_OFS    = 321,
    parameter int          Y_OFS    = 161,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter int          ADDR_W   = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        edge_bit,
    input  logic        edge_valid,
    input  logic        edge_sof,
    input  logic        disp_sof,
    input  logic        pix_req,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic [15:0] pix_data,
    output logic        front_bank,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int                DEPTH     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ROW_W     = ADDR_W'(IMG_W);
    localparam logic [10:0]       X_LO      = 11'(X_OFS);
    localparam logic [10:0]       X_HI      = 11'(X_OFS + IMG_W);
    localparam logic [10:0]       Y_LO      = 11'(Y_OFS);
    localparam logic [10:0]       Y_HI      = 11'(Y_OFS + IMG_H);

    typedef enum logic [1:0] {
        W_SYNC = 2'd0,
        W_FILL = 2'd1,
        W_HOLD = 2'd2
    } wstate_t;

    wstate_t           state_r, state_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [ADDR_W-1:0] waddr_s;
    logic              we_s, done_s, err_s, swap_s;
    logic              front_bank_r, front_valid_r;
    logic              frame_done_r, sync_err_r;
    logic [15:0]       pix_data_r;
    logic              mem_r [2][DEPTH];

    logic [10:0]       dx_s, dy_s;
    logic              in_win_s, rd_bit_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // Write FSM: next state, write strobe and status pulses
    always_comb begin
        state_s   = state_r;
        wr_addr_s = wr_addr_r;
        waddr_s   = wr_addr_r;
        we_s      = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        swap_s    = 1'b0;
        case (state_r)
            W_SYNC: begin
                if (edge_valid && edge_sof) begin
                    we_s      = 1'b1;
                    waddr_s   = ADDR_ZERO;
                    wr_addr_s = ADDR_ONE;
                    state_s   = W_FILL;
                end else begin
                    state_s = W_SYNC;
                end
            end
            W_FILL: begin
                if (edge_valid) begin
                    we_s = 1'b1;
                    if (edge_sof && (wr_addr_r != ADDR_ZERO)) begin
                        // Upstream restarted: realign this frame to address 0
                        waddr_s   = ADDR_ZERO;
                        wr_addr_s = ADDR_ONE;
                        err_s     = 1'b1;
                    end else if (wr_addr_r == LAST_ADDR) begin
                        wr_addr_s = ADDR_ZERO;
                        done_s    = 1'b1;
                        state_s   = W_HOLD;
                    end else begin
                        wr_addr_s = wr_addr_r + ADDR_ONE;
                    end
                end else begin
                    state_s = W_FILL;
                end
            end
            W_HOLD: begin
                if (disp_sof) begin
                    swap_s  = 1'b1;
                    state_s = W_SYNC;
                end else begin
                    state_s = W_HOLD;
                end
            end
            default: begin
                state_s   = W_SYNC;
                wr_addr_s = ADDR_ZERO;
            end
        endcase
    end

    // Write FSM, bank selection and status pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= W_SYNC;
            wr_addr_r     <= ADDR_ZERO;
            front_bank_r  <= 1'b0;
            front_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_addr_r    <= wr_addr_s;
            frame_done_r <= done_s;
            sync_err_r   <= err_s;
            if (swap_s) begin
                front_bank_r  <= ~front_bank_r;
                front_valid_r <= 1'b1;
            end else begin
                front_bank_r  <= front_bank_r;
                front_valid_r <= front_valid_r;
            end
        end
    end

    // Bank storage: only the back bank is ever written, contents survive reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[~front_bank_r][waddr_s] <= edge_bit;
        end
    end

    // Read address and window test for the requested screen pixel
    always_comb begin
        dx_s      = pix_x - X_LO;
        dy_s      = pix_y - Y_LO;
        in_win_s  = (pix_x >= X_LO) && (pix_x < X_HI) && (pix_y >= Y_LO) && (pix_y < Y_HI);
        rd_addr_s = ADDR_W'(dy_s) * ROW_W + ADDR_W'(dx_s);
        if (in_win_s) begin
            rd_bit_s = mem_r[front_bank_r][rd_addr_s];
        end else begin
            rd_bit_s = 1'b0;
        end
    end

    // Colour output register, holds between requests
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_data_r <= BG_COLOR;
        end else if (pix_req) begin
            pix_data_r <= (in_win_s && front_valid_r && rd_bit_s) ? FG_COLOR : BG_COLOR;
        end else begin
            pix_data_r <= pix_data_r;
        end
    end

    assign pix_data   = pix_data_r;
    assign front_bank = front_bank_r;
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_edge_frame_buffer.sv
// Randomised bench for edge_frame_buffer against a frame-level reference model
// (per-bank bit images, write cursor and display bookkeeping kept as plain integers).
module tb_edge_frame_buffer;

    localparam int          W  = 158;
    localparam int          H  = 158;
    localparam int          N  = W * H;
    localparam int          XO = 321;
    localparam int          YO = 161;
    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        edge_bit = 1'b0, edge_valid = 1'b0, edge_sof = 1'b0, disp_sof = 1'b0;
    logic        pix_req = 1'b0;
    logic [10:0] pix_x = 11'd0, pix_y = 11'd0;
    logic [15:0] pix_data;
    logic        front_bank, frame_done, sync_err;

    edge_frame_buffer dut (
        .clk(clk), .rstn(rstn), .edge_bit(edge_bit), .edge_valid(edge_valid),
        .edge_sof(edge_sof), .disp_sof(disp_sof), .pix_req(pix_req),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .front_bank(front_bank),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: images per bank, displayed bank, and where the writer is in a frame
    bit img_m [2][N];
    int front_m, shown_m, holding_m, waiting_m, pos_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        front_m = 0; shown_m = 0; holding_m = 0; waiting_m = 1; pos_m = 0;
    endtask

    task automatic send_pixel(input bit b, input bit s, input bit d);
        int done_e = 0;
        int err_e = 0;
        edge_valid = 1'b1; edge_bit = b; edge_sof = s; disp_sof = d;
        if (holding_m != 0) begin
            if (d) begin
                front_m = 1 - front_m; shown_m = 1; holding_m = 0; waiting_m = 1;
            end
        end else if (waiting_m != 0) begin
            if (s) begin
                img_m[1 - front_m][0] = b; pos_m = 1; waiting_m = 0;
            end
        end else if (s) begin
            img_m[1 - front_m][0] = b; pos_m = 1; err_e = 1;
        end else begin
            img_m[1 - front_m][pos_m] = b;
            if (pos_m == N - 1) begin
                done_e = 1; holding_m = 1; pos_m = 0;
            end else begin
                pos_m++;
            end
        end
        @(posedge clk); #1;
        edge_valid = 1'b0; edge_sof = 1'b0; disp_sof = 1'b0;
        check_eq("frame_done", {31'd0, frame_done}, done_e);
        check_eq("sync_err", {31'd0, sync_err}, err_e);
        check_eq("front_bank", {31'd0, front_bank}, front_m);
        if ($urandom_range(15) == 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_disp();
        disp_sof = 1'b1;
        if (holding_m != 0) begin
            front_m = 1 - front_m; shown_m = 1; holding_m = 0; waiting_m = 1;
        end
        @(posedge clk); #1;
        disp_sof = 1'b0;
        check_eq("swap_bank", {31'd0, front_bank}, front_m);
    endtask

    task automatic read_px(input int x, input int y);
        int dx = x - XO;
        int dy = y - YO;
        logic [15:0] e = BG;
        if (dx >= 0 && dx < W && dy >= 0 && dy < H && shown_m != 0 && img_m[front_m][dy * W + dx])
            e = FG;
        pix_req = 1'b1; pix_x = 11'(x); pix_y = 11'(y);
        @(posedge clk); #1;
        pix_req = 1'b0;
        check_eq("pix_data", {16'd0, pix_data}, {16'd0, e});
    endtask

    task automatic read_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1) == 0)
                read_px($urandom_range(799), $urandom_range(479));
            else
                read_px($urandom_range(XO + W + 2, XO - 3), $urandom_range(YO + H + 2, YO - 3));
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pix", {16'd0, pix_data}, 32'h0);
        check_eq("rst_front", {31'd0, front_bank}, 32'd0);
        check_eq("rst_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_err", {31'd0, sync_err}, 32'd0);
        rstn = 1'b1;

        // Sparse screen sweep with nothing displayed yet
        for (int y = 0; y < 480; y += 8)
            for (int x = 0; x < 800; x += 9)
                read_px(x, y);

        // Pixels before any edge_sof are dropped
        repeat (20) send_pixel(1'($urandom_range(1)), 1'b0, 1'b0);

        // Checkerboard frame
        for (int i = 0; i < N; i++)
            send_pixel(((i / W) + (i % W)) % 2 == 0, i == 0, 1'b0);
        read_rand(50);
        pulse_disp();
        check_eq("cb_front", {31'd0, front_bank}, 32'd1);
        read_px(321, 161);
        check_eq("cb_origin", {16'd0, pix_data}, {16'd0, FG});
        pix_x = 11'd5; pix_y = 11'd5;
        @(posedge clk); #1;
        check_eq("pix_hold", {16'd0, pix_data}, {16'd0, FG});
        read_px(322, 161);
        check_eq("cb_second", {16'd0, pix_data}, {16'd0, BG});
        read_rand(200);

        // All-ones frame: restart at wr_addr 500, disp_sof on the last write is not a swap
        for (int i = 0; i < 500; i++)
            send_pixel(1'b1, i == 0, 1'b0);
        for (int i = 0; i < N; i++)
            send_pixel(1'b1, i == 0, i == N - 1);
        check_eq("no_swap_on_last", {31'd0, front_bank}, 32'd1);
        read_rand(100);

        // A frame arriving while the back bank is held is dropped
        for (int i = 0; i < 300; i++)
            send_pixel(1'($urandom_range(1)), i == 0, 1'b0);
        read_rand(100);
        pulse_disp();
        check_eq("ones_front", {31'd0, front_bank}, 32'd0);

        read_px(320, 161); check_eq("edge_left", {16'd0, pix_data}, {16'd0, BG});
        read_px(479, 161); check_eq("edge_right", {16'd0, pix_data}, {16'd0, BG});
        read_px(321, 160); check_eq("edge_top", {16'd0, pix_data}, {16'd0, BG});
        read_px(321, 319); check_eq("edge_bottom", {16'd0, pix_data}, {16'd0, BG});
        read_px(478, 318); check_eq("corner_br", {16'd0, pix_data}, {16'd0, FG});
        read_px(321, 161); check_eq("corner_tl", {16'd0, pix_data}, {16'd0, FG});
        read_rand(200);

        // Partial random frame then reset mid-write
        for (int i = 0; i < 1000; i++)
            send_pixel(1'($urandom_range(1)), i == 0, 1'b0);
        read_px(400, 200);
        check_eq("pre_rst_pix", {16'd0, pix_data}, {16'd0, FG});
        rstn = 1'b0;
        #2;
        check_eq("mid_rst_pix", {16'd0, pix_data}, 32'h0);
        check_eq("mid_rst_front", {31'd0, front_bank}, 32'd0);
        check_eq("mid_rst_done", {31'd0, frame_done}, 32'd0);
        check_eq("mid_rst_err", {31'd0, sync_err}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        read_rand(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
